acc_operand_consumer: RTL
=========================

// Module: acc_operand_consumer
// PURPOSE
//  Consumer end of the accumulator put/op protocol. On an op instruction it reads the
//  accumulator's r0..r2 and valid flags, then executes the opcode (sequentially for
//  MUL). It returns an 8-bit result, pulses consume so the accumulator clears its
//  valid bits, and flags operand or opcode errors. It sits between the accumulator
//  and the register-file writeback.
// PARAMETERS
//  PC_W      12  program counter width
//  DW        8   operand/result width
//  MUL_CYC   8   shift-add iterations for MUL (= DW)
// PORTS
//  clk        in   1     system clock, all state on posedge
//  reset      in   1     asynchronous, active-high; clears all state immediately
//  op_en      in   1     current instruction is an op instruction
//  opcode     in   3     op_pkg::op_e
//  prog_ctr   in   PC_W  current PC; an op is accepted once per distinct PC value
//  r0,r1,r2   in   DW    accumulator operand registers
//  r0_valid   in   1     operand valid flags (r1_valid, r2_valid likewise)
//  result     out  DW    last computed result; held until the next good result
//  carry      out  1     carry/borrow of ADD/SUB/ADD3; 0 for other ops
//  result_valid out 1    one-cycle pulse when result/carry update
//  consume    out  1     one-cycle pulse; the accumulator clears r*_valid on it
//  busy       out  1     high from acceptance until the result/err cycle inclusive
//  err        out  1     one-cycle pulse: missing operands or illegal opcode
//  overrun    out  1     sticky: op_en at a new PC arrived while busy; clears only on reset
// BEHAVIOUR
//  Reset value of every output is 0. old_pc resets to all-ones, so an op at PC 'hFFF
//    directly after reset is ignored (this is defined behaviour).
//  Acceptance: at a posedge in IDLE with op_en=1 and prog_ctr!=old_pc: latch opcode,
//    r0..r2 and the valid flags, set old_pc<=prog_ctr and busy<=1, then go to EXEC.
//    The PC still updates when op_en=0.
//  FSM: IDLE -> EXEC -> DONE -> IDLE.
//    - EXEC lasts 1 cycle for combinational ops and MUL_CYC cycles for MUL.
//    - DONE drives result_valid or err, plus consume, for exactly one cycle.
//    - busy is 0 only in IDLE.
//  Latency: ALU op accepted at edge N -> result_valid high after edge N+2.
//    MUL accepted at edge N -> result_valid after edge N+1+MUL_CYC.
//  Opcodes and required valids:
//    ADD  r0+r1 (needs r0,r1)
//    SUB  r0-r1 (needs r0,r1; carry=borrow)
//    AND, OR, XOR (need r0,r1)
//    NOT  ~r0 (needs r0)
//    ADD3 r0+r1+r2 (needs all three; carry=1 if sum>255)
//    MUL  low DW bits of r0*r1 (needs r0,r1)
//  Wrap-around: results are truncated mod 2^DW; the carry captures the overflow.
//  Missing operand: in DONE, err=1 and consume=1; result/carry are unchanged and
//    result_valid=0. Extra valid operands beyond those required are ignored and
//    still consumed.
//  An op_en at a new PC while busy is dropped: overrun<=1, and old_pc still updates
//    (no retry).
//  consume is always issued, including on err; this guarantees the accumulator
//    never deadlocks full.
//  Inputs r0..r2 may change after acceptance; only the latched copies are used.
//  Reset mid-MUL: abort immediately, return to IDLE, and emit no consume.
// CONFIGURATION
//  ACC_CONSUMER_MUL_EN defined: MUL runs via the sequential multiplier as above.
//  Not defined: the multiplier is not instantiated and MUL is an illegal opcode.
//    An illegal opcode takes EXEC 1 cycle, then DONE with err=1 and consume=1.
// STRUCTURE
//  op_pkg:
//    - typedef enum logic[2:0] op_e {ADD,SUB,AND,OR,XOR,NOT,ADD3,MUL}
//    - typedef enum state_e {IDLE,EXEC,DONE}
//    - localparam need mask per opcode (3-bit r2r1r0)
//  Sub-module seq_mul8: start/done handshake, MUL_CYC shift-add steps, async reset.
//    Only instantiated under ACC_CONSUMER_MUL_EN.
// TESTING
//  1 ADD: r0=200 r1=100 all valid, op_en PC=5
//      -> result=44 carry=1 result_valid at edge N+2, consume same cycle.
//  2 SUB borrow: r0=3 r1=5 -> result=254 carry=1.
//    ADD3: 10,20,30 with r2 valid -> result=60 carry=0.
//  3 Missing operand: ADD3 with r2_valid=0 -> err=1, consume=1, result_valid=0,
//      result keeps its previous value.
//  4 MUL: r0=13 r1=11 -> result=143 after edge N+9, busy high throughout.
//    Second op_en at a new PC during MUL -> overrun=1 and no second result.
//  5 PC dedupe: op_en held for 3 cycles at PC=7 -> exactly one consume.
//    Post-reset op at PC=0 is accepted.
//  6 Reset asserted at MUL cycle 4 -> all outputs 0 immediately, no consume.
//    Without ACC_CONSUMER_MUL_EN: MUL -> err after 2 edges.

Source files
------------

// File: rtl/op_pkg.sv
// op_pkg: opcode/state types and per-opcode operand-need masks for acc_operand_consumer.
package op_pkg;
    localparam int MUL_CYC = 8;
    typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, NOT, ADD3, MUL} op_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    localparam logic [2:0] NEED_R0  = 3'b001;
    localparam logic [2:0] NEED_R01 = 3'b011;
    localparam logic [2:0] NEED_ALL = 3'b111;
    function automatic logic [2:0] need_mask(op_e op);
        return op == NOT ? NEED_R0 : op == ADD3 ? NEED_ALL : NEED_R01;
    endfunction
endpackage

// File: rtl/seq_mul8.sv
// seq_mul8: shift-add multiplier, low DW bits of a*b after CYC steps; o_done marks the final step.
module seq_mul8 #(
    parameter int DW  = 8,
    parameter int CYC = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_done,
    output logic [DW-1:0] o_prod
);
    localparam int CW = $clog2(CYC + 1);
    logic [DW-1:0] r_a, r_b;
    logic [CW-1:0] r_cnt;
    assign o_done = r_cnt == CW'(1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            o_prod <= '0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_cnt  <= CW'(CYC);
            o_prod <= '0;
        end else if (r_cnt != '0) begin
            if (r_b[0]) o_prod <= o_prod + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/acc_operand_consumer.sv
// acc_operand_consumer: consumes accumulator operands on op instructions and returns an 8-bit result.
// Optional ACC_CONSUMER_MUL_EN adds the sequential multiplier; otherwise MUL is an illegal opcode.
module acc_operand_consumer
    import op_pkg::*;
#(
    parameter int PC_W = 12,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_en,
    input  op_e             opcode,
    input  logic [PC_W-1:0] prog_ctr,
    input  logic [DW-1:0]   r0,
    input  logic [DW-1:0]   r1,
    input  logic [DW-1:0]   r2,
    input  logic            r0_valid,
    input  logic            r1_valid,
    input  logic            r2_valid,
    output logic [DW-1:0]   result,
    output logic            carry,
    output logic            result_valid,
    output logic            consume,
    output logic            busy,
    output logic            err,
    output logic            overrun
);
    state_e          r_state;
    op_e             r_op;
    logic [DW-1:0]   r_a, r_b, r_c;
    logic [2:0]      r_vld;
    logic [PC_W-1:0] r_old_pc;
    logic            w_new, w_accept, w_legal, w_ok, w_exec_done, w_cy;
    logic [DW:0]     w_sum, w_diff;
    logic [DW+1:0]   w_sum3;
    logic [DW-1:0]   w_res, w_prod;

    assign w_new    = op_en && prog_ctr != r_old_pc;
    assign w_accept = w_new && !busy;
`ifdef ACC_CONSUMER_MUL_EN
    logic w_mul_done;
    seq_mul8 #(.DW(DW), .CYC(MUL_CYC)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept && opcode == MUL),
        .i_a     (r0),
        .i_b     (r1),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
    assign w_legal     = 1'b1;
    assign w_exec_done = r_op != MUL || w_mul_done;
`else
    assign w_prod      = '0;
    assign w_legal     = r_op != MUL;
    assign w_exec_done = 1'b1;
`endif
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_sum3 = {2'b0, r_a} + {2'b0, r_b} + {2'b0, r_c};
    assign w_ok   = w_legal && (need_mask(r_op) & r_vld) == need_mask(r_op);

    always_comb begin
        w_res = w_prod;
        w_cy  = 1'b0;
        case (r_op)
            ADD:  {w_cy, w_res} = w_sum;
            SUB:  {w_cy, w_res} = w_diff;
            AND:  w_res = r_a & r_b;
            OR:   w_res = r_a | r_b;
            XOR:  w_res = r_a ^ r_b;
            NOT:  w_res = ~r_a;
            ADD3: begin
                w_res = w_sum3[DW-1:0];
                w_cy  = |w_sum3[DW+1:DW];
            end
            default: ;
        endcase
    end

    // busy stays high through the result cycle, so acceptance only needs !busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_vld        <= '0;
            r_old_pc     <= '1;
            result       <= '0;
            carry        <= 1'b0;
            result_valid <= 1'b0;
            consume      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            r_old_pc     <= prog_ctr;
            result_valid <= 1'b0;
            consume      <= 1'b0;
            err          <= 1'b0;
            if (w_new && busy) overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    busy <= w_accept;
                    if (w_accept) begin
                        r_state <= EXEC;
                        r_op    <= opcode;
                        r_a     <= r0;
                        r_b     <= r1;
                        r_c     <= r2;
                        r_vld   <= {r2_valid, r1_valid, r0_valid};
                    end
                end
                EXEC: if (w_exec_done) r_state <= DONE;
                DONE: begin
                    r_state      <= IDLE;
                    consume      <= 1'b1;
                    result_valid <= w_ok;
                    err          <= !w_ok;
                    if (w_ok) begin
                        result <= w_res;
                        carry  <= w_cy;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
